// File: rtl/univ_reg.sv
// Universal WIDTH-bit register: hold, parallel load, shift, rotate, modulo up/down
// count and sync clear, with async active-low reset and a terminal count for cascading.
module univ_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] MAX       = '1
) (
    input  logic             CLK,
    input  logic             RSTdash,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qdash,
    output logic             SOL,
    output logic             SOR,
    output logic             TC
);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_LOAD  = 3'b001,
        M_SHL   = 3'b010,
        M_SHR   = 3'b011,
        M_UP    = 3'b100,
        M_DOWN  = 3'b101,
        M_ROTL  = 3'b110,
        M_CLR   = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_e            mode;
    logic [WIDTH-1:0] q_nxt;
    logic             at_top;
    logic             at_zero;

    assign mode    = mode_e'(MODE);
    // Q above MAX (e.g. after loading a large D) counts as already at the top.
    assign at_top  = (Q >= MAX);
    assign at_zero = (Q == '0);

    always_comb begin
        q_nxt = Q;
        case (mode)
            M_HOLD: q_nxt = Q;
            M_LOAD: q_nxt = D;
            M_SHL:  q_nxt = {Q[WIDTH-2:0], SIL};
            M_SHR:  q_nxt = {SIR, Q[WIDTH-1:1]};
            M_UP:   q_nxt = at_top  ? '0  : Q + ONE;
            M_DOWN: q_nxt = at_zero ? MAX : Q - ONE;
            M_ROTL: q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
            M_CLR:  q_nxt = RESET_VAL;
            default: q_nxt = Q;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTdash) begin
        if (!RSTdash)
            Q <= RESET_VAL;
        else if (EN)
            Q <= q_nxt;
    end

    assign Qdash = ~Q;
    assign SOL   = Q[WIDTH-1];
    assign SOR   = Q[0];
    // High in the cycle whose next edge wraps; feeds the next stage's EN.
    assign TC    = EN & (((mode == M_UP) & at_top) | ((mode == M_DOWN) & at_zero));

endmodule

// File: tb/tb_univ_reg.sv
// Scoreboard bench for univ_reg: two 8-bit registers sharing stimulus plus a
// two-stage decade cascade, checked against an integer reference model.
module tb_univ_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sil;
    logic       sir;
    logic       cen;
    logic [2:0] cmode;
    logic [3:0] czero;
    logic       zbit;

    logic [7:0] a_q, a_qd, b_q, b_qd;
    logic       a_sol, a_sor, a_tc, b_sol, b_sor, b_tc;
    logic [3:0] l_q, l_qd, h_q, h_qd;
    logic       l_sol, l_sor, l_tc, h_sol, h_sor, h_tc;

    univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .MAX(8'hFF)) ua (
        .CLK(clk), .RSTdash(rst_n), .EN(en), .MODE(mode), .D(d), .SIL(sil), .SIR(sir),
        .Q(a_q), .Qdash(a_qd), .SOL(a_sol), .SOR(a_sor), .TC(a_tc));

    univ_reg #(.WIDTH(8), .RESET_VAL(8'h00), .MAX(8'd9)) ub (
        .CLK(clk), .RSTdash(rst_n), .EN(en), .MODE(mode), .D(d), .SIL(sil), .SIR(sir),
        .Q(b_q), .Qdash(b_qd), .SOL(b_sol), .SOR(b_sor), .TC(b_tc));

    univ_reg #(.WIDTH(4), .RESET_VAL(4'h0), .MAX(4'd9)) ulo (
        .CLK(clk), .RSTdash(rst_n), .EN(cen), .MODE(cmode), .D(czero), .SIL(zbit), .SIR(zbit),
        .Q(l_q), .Qdash(l_qd), .SOL(l_sol), .SOR(l_sor), .TC(l_tc));

    univ_reg #(.WIDTH(4), .RESET_VAL(4'h0), .MAX(4'd9)) uhi (
        .CLK(clk), .RSTdash(rst_n), .EN(l_tc), .MODE(cmode), .D(czero), .SIL(zbit), .SIR(zbit),
        .Q(h_q), .Qdash(h_qd), .SOL(h_sol), .SOR(h_sor), .TC(h_tc));

    typedef struct {
        string tag;
        int    qa, qb, cl, ch;
        bit    ta, tb, tl, th;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // reference state: two registers as plain integers, cascade as a 0..99 decimal count
    int qa, qb, cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int nxt(input int q, input int m, input int dd, input int sl,
                               input int sr, input int mx, input int rv);
        case (m)
            1: return dd;
            2: return (q * 2 + sl) % 256;
            3: return q / 2 + sr * 128;
            4: return (q >= mx) ? 0 : q + 1;
            5: return (q == 0) ? mx : q - 1;
            6: return (q * 2) % 256 + q / 128;
            7: return rv;
            default: return q;
        endcase
    endfunction

    // One cycle: retire the previous edge in the model, drive new inputs between
    // edges (reset included), and queue what the DUT must show before the next edge.
    task automatic step(input string tag, input int m, input bit e, input int dd,
                        input bit sl, input bit sr, input bit r, input bit ce);
        exp_t x;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (en) begin
                qa = nxt(qa, int'(mode), int'(d), int'(sil), int'(sir), 255, 'hA5);
                qb = nxt(qb, int'(mode), int'(d), int'(sil), int'(sir), 9, 0);
            end
            if (cen) cnt = (cnt + 1) % 100;
        end
        mode  = 3'(m);
        en    = e;
        d     = 8'(dd);
        sil   = sl;
        sir   = sr;
        cen   = ce;
        rst_n = r;
        #1;
        if (!r) begin
            qa  = 'hA5;
            qb  = 0;
            cnt = 0;
        end
        x.tag = tag;
        x.qa  = qa;
        x.qb  = qb;
        x.cl  = cnt % 10;
        x.ch  = cnt / 10;
        x.ta  = e && ((m == 4 && qa >= 255) || (m == 5 && qa == 0));
        x.tb  = e && ((m == 4 && qb >= 9) || (m == 5 && qb == 0));
        x.tl  = ce && (cnt % 10 == 9);
        x.th  = x.tl && (cnt / 10 == 9);
        sb.push_back(x);
    endtask

    // monitor: registered outputs are presented every cycle; sample at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.tag, "/a.Q"},     int'(a_q),   e.qa);
                chk({e.tag, "/a.Qdash"}, int'(a_qd),  255 - e.qa);
                chk({e.tag, "/a.SOL"},   int'(a_sol), e.qa / 128);
                chk({e.tag, "/a.SOR"},   int'(a_sor), e.qa % 2);
                chk({e.tag, "/a.TC"},    int'(a_tc),  int'(e.ta));
                chk({e.tag, "/b.Q"},     int'(b_q),   e.qb);
                chk({e.tag, "/b.Qdash"}, int'(b_qd),  255 - e.qb);
                chk({e.tag, "/b.SOL"},   int'(b_sol), e.qb / 128);
                chk({e.tag, "/b.SOR"},   int'(b_sor), e.qb % 2);
                chk({e.tag, "/b.TC"},    int'(b_tc),  int'(e.tb));
                chk({e.tag, "/lo.Q"},    int'(l_q),   e.cl);
                chk({e.tag, "/lo.Qdash"},int'(l_qd),  15 - e.cl);
                chk({e.tag, "/lo.SOL"},  int'(l_sol), e.cl / 8);
                chk({e.tag, "/lo.SOR"},  int'(l_sor), e.cl % 2);
                chk({e.tag, "/lo.TC"},   int'(l_tc),  int'(e.tl));
                chk({e.tag, "/hi.Q"},    int'(h_q),   e.ch);
                chk({e.tag, "/hi.Qdash"},int'(h_qd),  15 - e.ch);
                chk({e.tag, "/hi.SOL"},  int'(h_sol), e.ch / 8);
                chk({e.tag, "/hi.SOR"},  int'(h_sor), e.ch % 2);
                chk({e.tag, "/hi.TC"},   int'(h_tc),  int'(e.th));
            end
        end
    end

    initial begin
        int m, dd;
        bit e, sl, sr, r, ce;
        rst_n = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sil = 1'b0; sir = 1'b0;
        cen = 1'b0; cmode = 3'b100; czero = 4'h0; zbit = 1'b0;
        qa = 0; qb = 0; cnt = 0;

        // reset pulled low between edges with a load pending, held across edges
        step("rst_pulse", 1, 1, 'hFF, 0, 0, 0, 0);
        repeat (2) step("rst_hold", 1, 1, 'hFF, 0, 0, 0, 0);
        step("rst_rel", 0, 0, 0, 0, 0, 1, 0);

        // load then disabled load, then enabled hold
        step("load3C", 1, 1, 'h3C, 0, 0, 1, 0);
        repeat (3) step("en_off", 1, 0, 'hFF, 0, 0, 1, 0);
        repeat (2) step("hold", 0, 1, 'hFF, 0, 0, 1, 0);

        // shift / rotate from 81
        step("load81", 1, 1, 'h81, 0, 0, 1, 0);
        step("shl", 2, 1, 0, 0, 0, 1, 0);
        step("shr", 3, 1, 0, 0, 1, 1, 0);
        step("rotl", 6, 1, 0, 0, 0, 1, 0);
        step("hold", 0, 1, 0, 0, 0, 1, 0);

        // modulo count: wrap up and down, and clamp from above MAX
        step("load0", 1, 1, 0, 0, 0, 1, 0);
        repeat (11) step("up", 4, 1, 0, 0, 0, 1, 0);
        repeat (3) step("down", 5, 1, 0, 0, 0, 1, 0);
        step("load0C", 1, 1, 'h0C, 0, 0, 1, 0);
        repeat (2) step("up_over", 4, 1, 0, 0, 0, 1, 0);
        step("load0", 1, 1, 0, 0, 0, 1, 0);
        repeat (2) step("down_wrap", 5, 1, 0, 0, 0, 1, 0);
        step("sclr", 7, 1, 0, 0, 0, 1, 0);
        step("hold", 0, 1, 0, 0, 0, 1, 0);

        // reset mid-count, then counting resumes from the reset value
        step("load0", 1, 1, 0, 0, 0, 1, 0);
        repeat (8) step("up", 4, 1, 0, 0, 0, 1, 0);
        step("mid_rst", 4, 1, 0, 0, 0, 0, 0);
        step("rst_rel", 4, 1, 0, 0, 0, 1, 0);
        repeat (3) step("resume", 4, 1, 0, 0, 0, 1, 0);

        // cascade: 100 enabled edges of the decade pair
        step("hold", 0, 0, 0, 0, 0, 1, 0);
        repeat (100) step("casc", 0, 0, 0, 0, 0, 1, 1);
        step("casc_end", 0, 0, 0, 0, 0, 1, 0);

        // randomized traffic with occasional async resets
        repeat (400) begin
            m  = int'($urandom_range(0, 7));
            e  = ($urandom_range(0, 3) != 0);
            dd = int'($urandom_range(0, 255));
            sl = 1'($urandom_range(0, 1));
            sr = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 39) != 0);
            ce = 1'($urandom_range(0, 1));
            step("rand", m, e, dd, sl, sr, r, ce);
        end

        step("drain", 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
